// File: rtl/qformat_pkg.sv
// Shared Q8.8 format constants, FSM states and helpers
// used by the fixed-point divider, multiplier and benches.
package qformat_pkg;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int ITER  = WIDTH + FRAC;
  localparam int CW    = $clog2(ITER);

  localparam logic [WIDTH-1:0] Q_MAX = 16'h7FFF;
  localparam logic [WIDTH-1:0] Q_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Two's complement magnitude; -32768 maps to 0x8000,
  // which is correct when the result is read as unsigned.
  function automatic logic [WIDTH-1:0] qabs(
    input logic [WIDTH-1:0] x
  );
    return x[WIDTH-1] ? -x : x;
  endfunction

endpackage

// File: rtl/qsat.sv
// Sign restore and saturation of an unsigned ITER-bit magnitude.
// Ports: mag/neg in; res (signed WIDTH), ovf out.
module qsat
  import qformat_pkg::*;
(
  input  logic [ITER-1:0]  mag,
  input  logic             neg,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  localparam logic [ITER-1:0] POS_LIM =
    {{FRAC{1'b0}}, Q_MAX};
  localparam logic [ITER-1:0] NEG_LIM =
    {{FRAC{1'b0}}, Q_MIN};

  logic zero;
  logic big_p;
  logic big_n;

  assign zero  = (mag == '0);
  assign big_p = (mag > POS_LIM);
  assign big_n = (mag > NEG_LIM);

  // Zero is always +0, whatever the sign.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (1'b1)
      zero: begin
        res = '0;
      end
      (!zero && neg && big_n): begin
        res = Q_MIN;
        ovf = 1'b1;
      end
      (!zero && neg && !big_n): begin
        res = -mag[WIDTH-1:0];
      end
      (!zero && !neg && big_p): begin
        res = Q_MAX;
        ovf = 1'b1;
      end
      default: begin
        res = mag[WIDTH-1:0];
      end
    endcase
  end

endmodule

// File: rtl/qdiv_seq.sv
// Sequential signed Q8.8 restoring divider, 1 bit/cycle.
// Ports: clk, rst_n, in_valid/in_ready, a, b,
//        out_valid/out_ready, result, ovf, dz.
module qdiv_seq
  import qformat_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             dz
);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [ITER-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic            neg;
  logic            a_neg;
  logic            zdiv;

  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [ITER-1:0]  dvd_nx;
  logic [WIDTH-1:0] sat_res;
  logic             sat_ovf;

  // Remainder stays below the divisor (<= 0x8000), so
  // 16 bits hold it; the shifted value needs 17.
  // Quotient bits shift into the dividend register LSB,
  // so after ITER steps dvd holds the full quotient.
  assign r_sh   = {rem, dvd[ITER-1]};
  assign ge     = (r_sh >= {1'b0, dvs});
  assign rem_nx = ge ? WIDTH'(r_sh - {1'b0, dvs})
                     : r_sh[WIDTH-1:0];
  assign dvd_nx = {dvd[ITER-2:0], ge};

  qsat u_sat (
    .mag (dvd_nx),
    .neg (neg),
    .res (sat_res),
    .ovf (sat_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      neg       <= 1'b0;
      a_neg     <= 1'b0;
      zdiv      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            dvd      <= {qabs(a), {FRAC{1'b0}}};
            dvs      <= qabs(b);
            neg      <= a[WIDTH-1] ^ b[WIDTH-1];
            a_neg    <= a[WIDTH-1];
            zdiv     <= (b == '0);
            rem      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nx;
          dvd <= dvd_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            if (zdiv) begin
              result <= a_neg ? Q_MIN : Q_MAX;
              ovf    <= 1'b0;
              dz     <= 1'b1;
            end else begin
              result <= sat_res;
              ovf    <= sat_ovf;
              dz     <= 1'b0;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qdiv_seq.sv
// Self-checking bench for qdiv_seq: directed and random
// divisions against an arithmetic Q8.8 reference model.
module tb_qdiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ovf;
  logic        dz;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] prev_res;

  qdiv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Sign-magnitude divide with truncation toward zero,
  // then clamp to the signed 16-bit range.
  function automatic void model(
    input  logic [15:0] ta,
    input  logic [15:0] tb,
    output logic [15:0] r,
    output logic        o,
    output logic        z
  );
    int ma, mb, q;
    bit ng;
    ma = ta[15] ? 65536 - int'(ta) : int'(ta);
    mb = tb[15] ? 65536 - int'(tb) : int'(tb);
    ng = ta[15] ^ tb[15];
    z  = (mb == 0);
    o  = 1'b0;
    r  = 16'h0000;
    if (z) begin
      r = ta[15] ? 16'h8000 : 16'h7FFF;
    end else begin
      q = (ma * 256) / mb;
      if (q == 0) begin
        r = 16'h0000;
      end else if (!ng && q > 32767) begin
        r = 16'h7FFF;
        o = 1'b1;
      end else if (ng && q > 32768) begin
        r = 16'h8000;
        o = 1'b1;
      end else begin
        r = ng ? 16'(-q) : 16'(q);
      end
    end
  endfunction

  task automatic run(
    input string       tag,
    input logic [15:0] ta,
    input logic [15:0] tb,
    input int          hold
  );
    logic [15:0] er;
    logic        eo, ez;
    int          n;
    bit          seen;
    model(ta, tb, er, eo, ez);
    @(negedge clk);
    check({tag, ":rdy"}, 32'(in_ready), 32'd1);
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    n        = 0;
    seen     = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      seen = out_valid;
      if (n == 12)
        check({tag, ":hold"}, 32'(result),
              32'(prev_res));
    end
    check({tag, ":lat"}, 32'(n), 32'd24);
    @(negedge clk);
    check({tag, ":res"},
          32'({result, ovf, dz}),
          32'({er, eo, ez}));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      a        = 16'($urandom);
      b        = 16'($urandom);
      @(posedge clk);
      #1;
      check({tag, ":bp"},
            32'({out_valid, in_ready, result, ovf, dz}),
            32'({1'b1, 1'b0, er, eo, ez}));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ":ret"},
          32'({out_valid, in_ready}),
          32'({1'b0, 1'b1}));
    prev_res = er;
  endtask

  initial begin : main
    logic [15:0] ra, rb;
    int          n;
    bit          seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    prev_res  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset",
          32'({in_ready, out_valid, result, ovf, dz}),
          32'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}));
    rst_n = 1'b1;

    run("3/2",      16'h0300, 16'h0200, 0);
    run("-3/.5",    16'hFD00, 16'h0080, 0);
    run(".25/.25",  16'h0040, 16'h0040, 0);
    run("1/3",      16'h0100, 16'h0300, 0);
    run("-1/3",     16'hFF00, 16'h0300, 0);
    run("100/.25",  16'h6400, 16'h0040, 0);
    run("-128/-1",  16'h8000, 16'hFF00, 0);
    run("1/0",      16'h0100, 16'h0000, 0);
    run("-1/0",     16'hFF00, 16'h0000, 0);
    run("0/0",      16'h0000, 16'h0000, 0);
    run("-128/1",   16'h8000, 16'h0100, 0);
    run("min/min",  16'h8000, 16'h8000, 0);
    run("0/-1",     16'h0000, 16'hFF00, 0);
    run("tiny/neg", 16'hFFFF, 16'h7FFF, 0);
    run("bp",       16'h0500, 16'hFE00, 10);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 16'h0000;
        1, 2:    rb = 16'($urandom_range(1, 511));
        default: rb = 16'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1 && rb != 0)
        rb = -rb;
      run($sformatf("rnd%0d", i), ra, rb, 0);
    end

    @(negedge clk);
    a        = 16'h0300;
    b        = 16'h0200;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_calc",
          32'({in_ready, out_valid, result, ovf, dz}),
          32'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n    = 1'b1;
    prev_res = '0;
    n        = 0;
    seen     = 1'b0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
      n++;
    end
    check("no_out", 32'(seen), 32'd0);
    run("after_rst", 16'h0100, 16'h0300, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
